// File: rtl/queue_drain.sv
// Drains an 8-entry byte queue one entry at a time and shifts each byte out serially, MSB first.
// Also provides a frame strobe, a wrapping frame counter and a sticky handshake-timeout flag.
module queue_drain #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clock_10KHZ,
  input  logic              reset,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        queue_state_in,
  output logic              dequeue_out,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              frame_done,
  output logic [7:0]        byte_count,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] Q_DEQUEUE = 2'd1;
  localparam logic [1:0] Q_WAIT    = 2'd2;

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_SHIFT, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift_q, shift_nxt;
  logic [CYC_W-1:0]  cyc_q, cyc_nxt;
  logic [BIT_W-1:0]  bit_q, bit_nxt;
  logic [GAP_W-1:0]  gap_q, gap_nxt;
  logic [TMO_W-1:0]  tmo_q, tmo_nxt;
  logic              deq_nxt, err_nxt, valid_nxt, sout_nxt, done_nxt, busy_nxt;
  logic [7:0]        cnt_nxt;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    cyc_nxt   = cyc_q;
    bit_nxt   = bit_q;
    gap_nxt   = gap_q;
    tmo_nxt   = tmo_q;
    deq_nxt   = dequeue_out;
    cnt_nxt   = byte_count;
    err_nxt   = timeout_err;

    unique case (state)
      S_IDLE: begin
        // Requesting with an empty queue would wedge it in DEQUEUE.
        if (len_in != '0 && queue_state_in == Q_WAIT) begin
          state_nxt = S_REQ;
          deq_nxt   = 1'b1;
          tmo_nxt   = '0;
        end
      end
      S_REQ: begin
        // An ENQUEUE in progress simply delays the dequeue; keep holding the request.
        tmo_nxt = tmo_q + 1'b1;
        if (queue_state_in == Q_DEQUEUE) begin
          deq_nxt   = 1'b0;
          state_nxt = S_ACK;
        end else if (tmo_q == TMO_LAST) begin
          err_nxt   = 1'b1;
          deq_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        tmo_nxt = tmo_q + 1'b1;
        if (queue_state_in == Q_WAIT) begin
          shift_nxt = data_in;
          bit_nxt   = BIT_LAST;
          cyc_nxt   = '0;
          state_nxt = S_SHIFT;
        end else if (tmo_q == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cyc_q == CYC_LAST) begin
          cyc_nxt = '0;
          if (bit_q == '0) begin
            cnt_nxt   = byte_count + 8'd1;
            gap_nxt   = '0;
            state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            bit_nxt   = bit_q - 1'b1;
            shift_nxt = shift_q << 1;
          end
        end else begin
          cyc_nxt = cyc_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_nxt = S_IDLE;
        else                   gap_nxt   = gap_q + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    valid_nxt = (state_nxt == S_SHIFT);
    sout_nxt  = valid_nxt & shift_nxt[DATA_W-1];
    done_nxt  = valid_nxt && (bit_nxt == '0) && (cyc_nxt == CYC_LAST);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      shift_q      <= '0;
      cyc_q        <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      tmo_q        <= '0;
      dequeue_out  <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_done   <= 1'b0;
      byte_count   <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      shift_q      <= shift_nxt;
      cyc_q        <= cyc_nxt;
      bit_q        <= bit_nxt;
      gap_q        <= gap_nxt;
      tmo_q        <= tmo_nxt;
      dequeue_out  <= deq_nxt;
      serial_out   <= sout_nxt;
      serial_valid <= valid_nxt;
      frame_done   <= done_nxt;
      byte_count   <= cnt_nxt;
      busy         <= busy_nxt;
      timeout_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_queue_drain.sv
// Bench for queue_drain: a behavioural byte queue feeds the drain, and a frame-level model
// predicts the serial stream from the bytes the queue hands out.
module tb_queue_drain;
  localparam int DATA_W = 8, LEN_W = 4, BIT_CYCLES = 4, GAP_CYCLES = 2, TIMEOUT = 64;
  localparam int FRAME = DATA_W * BIT_CYCLES;
  localparam int Q_ENQ = 0, Q_DEQ = 1, Q_WAIT = 2;

  logic              clock_10KHZ = 1'b0;
  logic              reset = 1'b0;
  logic [LEN_W-1:0]  len_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [1:0]        queue_state_in = 2'd2;
  logic              dequeue_out, serial_out, serial_valid, frame_done, busy, timeout_err;
  logic [7:0]        byte_count;

  queue_drain #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BIT_CYCLES(BIT_CYCLES),
                .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clock_10KHZ(clock_10KHZ), .reset(reset), .len_in(len_in), .data_in(data_in),
    .queue_state_in(queue_state_in), .dequeue_out(dequeue_out), .serial_out(serial_out),
    .serial_valid(serial_valid), .frame_done(frame_done), .byte_count(byte_count),
    .busy(busy), .timeout_err(timeout_err));

  always #5 clock_10KHZ = ~clock_10KHZ;

  // queue model
  logic [7:0] q[$];
  int qst = Q_WAIT, enq_left = 0;
  bit enq_on_req = 0, stuck = 0;
  logic [7:0] enq_byte = 8'h00;
  // frame model
  int fp = -1;
  logic [7:0] cur = 8'h00, popped = 8'h00, bc = 8'h00;
  bit pend = 0, err_exp = 0, chk_err = 1;
  // monitors
  int deq_rises = 0, fd_cnt = 0, busy_cyc = 0, enq_hold = 0, vrun = 0, lrun = 0, last_vlen = 0;
  bit prev_deq = 0, prev_valid = 0, have_prev = 0;
  logic [7:0] col = 8'h00;
  logic [7:0] rx[$];
  int gaps[$];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    len_in = LEN_W'(q.size());
  endtask

  // One clock cycle: compare outputs with the model, update monitors, then advance the queue.
  task automatic cyc();
    logic exp_bit;
    @(negedge clock_10KHZ);
    if (!reset) begin
      fp = -1; pend = 0; bc = 8'h00; err_exp = 0;
      prev_deq = 0; prev_valid = 0; have_prev = 0; vrun = 0; lrun = 0;
      chk("rst_dequeue", dequeue_out, 0);
      chk("rst_serial_out", serial_out, 0);
      chk("rst_serial_valid", serial_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_byte_count", byte_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
    end else begin
      if (pend) begin fp = 0; cur = popped; pend = 0; end
      else if (fp >= 0) begin
        fp++;
        if (fp == FRAME) begin fp = -1; bc = bc + 8'd1; end
      end
      exp_bit = 1'b0;
      if (fp >= 0) exp_bit = cur[DATA_W - 1 - fp / BIT_CYCLES];
      chk("serial_valid", serial_valid, (fp >= 0) ? 1 : 0);
      chk("serial_out", serial_out, exp_bit);
      chk("frame_done", frame_done, (fp == FRAME - 1) ? 1 : 0);
      chk("byte_count", byte_count, bc);
      if (fp >= 0) begin
        chk("dequeue_in_frame", dequeue_out, 0);
        chk("busy_in_frame", busy, 1);
      end
      if (chk_err) chk("timeout_err", timeout_err, err_exp);

      if (dequeue_out && !prev_deq) deq_rises++;
      prev_deq = dequeue_out;
      if (frame_done) fd_cnt++;
      if (busy) busy_cyc++;
      if (dequeue_out && qst == Q_ENQ) enq_hold++;
      if (serial_valid) begin
        if (!prev_valid && have_prev) gaps.push_back(lrun);
        if (vrun % BIT_CYCLES == 1) col = {col[6:0], serial_out};
        vrun++; lrun = 0;
      end else begin
        if (prev_valid) begin last_vlen = vrun; rx.push_back(col); have_prev = 1; end
        vrun = 0; lrun++;
      end
      prev_valid = serial_valid;
    end

    case (qst)
      Q_WAIT: begin
        if (dequeue_out && enq_on_req) begin qst = Q_ENQ; enq_left = 3; enq_on_req = 0; end
        else if (dequeue_out && q.size() > 0 && !stuck) qst = Q_DEQ;
      end
      Q_ENQ: begin
        enq_left--;
        if (enq_left == 0) begin q.push_back(enq_byte); qst = Q_WAIT; end
      end
      default: begin
        popped = q.pop_front(); data_in = popped; pend = 1; qst = Q_WAIT;
      end
    endcase
    len_in = LEN_W'(q.size());
    queue_state_in = 2'(qst);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0, quiet = 0;
    while (quiet < 4 && n < budget) begin
      cyc(); n++;
      if (!busy && q.size() == 0 && qst == Q_WAIT) quiet++; else quiet = 0;
    end
    chk({name, "_settle"}, (quiet >= 4) ? 1 : 0, 1);
  endtask

  initial begin
    int b_deq, b_fd, b_busy, b_enq, n;

    // 1: reset held with a non-empty queue
    push(8'h11); push(8'h22); push(8'h33);
    repeat (5) cyc();
    chk("t1_len_seen", len_in, 3);
    chk("t1_dequeue", dequeue_out, 0);
    q.delete(); len_in = '0;
    cyc();
    reset = 1'b1;

    // 2: empty queue never requested
    b_deq = deq_rises; b_busy = busy_cyc;
    repeat (100) cyc();
    chk("t2_deq_rises", deq_rises - b_deq, 0);
    chk("t2_busy_cycles", busy_cyc - b_busy, 0);

    // 3: single byte 0xA5
    b_deq = deq_rises; b_fd = fd_cnt; rx.delete();
    push(8'hA5);
    wait_quiet(300, "t3");
    chk("t3_deq_rises", deq_rises - b_deq, 1);
    chk("t3_valid_len", last_vlen, 32);
    chk("t3_frames", rx.size(), 1);
    if (rx.size() > 0) chk("t3_byte", rx[0], 8'hA5);
    chk("t3_frame_done", fd_cnt - b_fd, 1);
    chk("t3_byte_count", byte_count, 1);

    // 4: three bytes in order
    do_reset();
    b_deq = deq_rises; rx.delete(); gaps.delete();
    push(8'h01); push(8'h80); push(8'hFF);
    wait_quiet(600, "t4");
    chk("t4_frames", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("t4_byte0", rx[0], 8'h01);
      chk("t4_byte1", rx[1], 8'h80);
      chk("t4_byte2", rx[2], 8'hFF);
    end
    chk("t4_gaps", gaps.size(), 2);
    // 2 GAP + 1 IDLE + 1 REQ + 1 ACK with a queue answering in one cycle
    if (gaps.size() == 2) begin
      chk("t4_gap0", gaps[0], 5);
      chk("t4_gap1", gaps[1], 5);
    end
    chk("t4_byte_count", byte_count, 3);
    chk("t4_len", len_in, 0);
    chk("t4_deq_rises", deq_rises - b_deq, 3);

    // 5: enqueue arrives together with the request
    do_reset();
    b_deq = deq_rises; b_enq = enq_hold; rx.delete();
    enq_on_req = 1; enq_byte = 8'h5A;
    push(8'h3C);
    wait_quiet(600, "t5");
    chk("t5_enq_hold", enq_hold - b_enq, 3);
    chk("t5_frames", rx.size(), 2);
    if (rx.size() == 2) begin
      chk("t5_byte0", rx[0], 8'h3C);
      chk("t5_byte1", rx[1], 8'h5A);
    end
    chk("t5_deq_rises", deq_rises - b_deq, 2);
    chk("t5_byte_count", byte_count, 2);
    chk("t5_timeout", timeout_err, 0);

    // 6: queue ignores the request, then reset during a frame
    do_reset();
    stuck = 1; chk_err = 0;
    push(8'h77);
    n = 0;
    while (!dequeue_out && n < 20) begin cyc(); n++; end
    chk("t6_request", dequeue_out, 1);
    n = 0;
    while (!timeout_err && n < 200) begin cyc(); n++; end
    chk("t6_timeout_cycles", n, TIMEOUT);
    chk("t6_timeout_flag", timeout_err, 1);
    chk("t6_dequeue_dropped", dequeue_out, 0);
    chk("t6_idle", busy, 0);
    err_exp = 1; chk_err = 1; stuck = 0;
    n = 0;
    while (!serial_valid && n < 50) begin cyc(); n++; end
    chk("t6_frame_started", serial_valid, 1);
    repeat (5) cyc();
    #2 reset = 1'b0;
    #1;
    chk("t6_abort_valid", serial_valid, 0);
    chk("t6_abort_count", byte_count, 0);
    chk("t6_abort_timeout", timeout_err, 0);
    repeat (2) cyc();
    reset = 1'b1;
    repeat (10) cyc();
    chk("t6_after_count", byte_count, 0);
    chk("t6_after_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
